prod_accum: RTL and testbench
=============================

# prod_accum

Sequential accumulator that sits directly downstream of the combinational array multiplier. It consumes one unsigned product per accepted beat, sums a fixed-length block of LEN products (a dot product), and presents the registered total on a valid/ready output. It turns the multiplier's per-cycle products into block results for the next stage.

## Interface
- IN_W, 8: product width; matches the multiplier's `sum` output.
- ACC_W, 16: accumulator and result width; must be ≥ IN_W.
- LEN, 4: products per block; must be ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous abort: drop the partial block, return to ACC.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  block can accept a product.
- in_prod  in  IN_W  unsigned product from the multiplier.
- out_valid  out  1  out_acc/out_ovf hold a finished block.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  block sum.
- out_ovf  out  1  sticky: the block overflowed ACC_W.

## Operation
- FSM with two states.
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept rule: a beat is accepted when in_valid && in_ready && !clr.
- On each accepted beat:
  - acc <= acc + zero-extended in_prod, computed ACC_W+1 wide.
  - A carry out sets ovf.
  - cnt increments.
- Block end: the beat accepted with cnt==LEN-1 moves the FSM to DONE. out_acc/out_ovf take the final sum; they are driven from the acc/ovf registers.
- Result hand-off: in DONE, out_valid && out_ready clears acc, ovf and cnt, and returns the FSM to ACC.
- Result stability: while out_ready=0 in DONE, out_acc and out_ovf are held stable. Input is stalled (in_ready=0).
- Clear:
  - clr=1 in any state sets acc=0, ovf=0, cnt=0 and state=ACC on the next edge.
  - in_ready is forced to 0 while clr=1.
  - clr wins over a simultaneous input or output handshake. A pending result is discarded.
- Overflow without saturation: the sum wraps modulo 2^ACC_W.
- in_valid=0 in ACC: no state change and no count.
- cnt width: $clog2(LEN), minimum 1 bit. It never exceeds LEN-1.

## Timing
- Reset values: state=ACC, acc=0, cnt=0, ovf=0. Outputs are in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
- Reset mid-block or mid-DONE discards all state immediately.
- Latency: out_valid rises on the edge that accepts the LEN-th product.
- Throughput: at most one product per cycle.
- Bubble: one dead input cycle per block (the DONE cycle in which out_ready=1). A block of LEN takes LEN+1 cycles minimum.
- out_valid never drops without out_ready, clr or reset.
- in_ready and out_valid are pure functions of registered state and clr. There is no combinational path from in_valid or out_ready.

## Configuration
- PROD_ACCUM_SAT_EN defined: an add that carries out clamps acc to 2^ACC_W-1 and sets ovf. Later adds stay clamped.
- PROD_ACCUM_SAT_EN undefined: the add wraps, and ovf is still set (sticky).

## Structure
- Package prod_accum_pkg holds:
  - the state enum (ST_ACC, ST_DONE);
  - default constants IN_W_DEF=8, ACC_W_DEF=16, LEN_DEF=4.
- Sub-module prod_accum_add: combinational ACC_W adder with carry-out. It contains the PROD_ACCUM_SAT_EN clamp, so the FSM stays macro-free.

## Test plan
- Basic block (defaults):
  - Stimulus: products 1, 15, 45, 50 on consecutive cycles, out_ready=1.
  - Response: out_valid for exactly one cycle, the cycle after the 4th accept. out_acc=111, out_ovf=0. in_ready=0 during DONE, then 1.
- Backpressure:
  - Stimulus: same block, out_ready=0 for 5 cycles, then 1.
  - Response: out_acc=111 held for 5 cycles. in_ready=0 throughout. The next block starts from acc=0.
- Overflow (ACC_W=8, LEN=2):
  - Stimulus: products 200, 100.
  - Response without the macro: out_acc=44, out_ovf=1. Response with PROD_ACCUM_SAT_EN: out_acc=255, out_ovf=1.
- Clear mid-block:
  - Stimulus: products 10, 20, then clr=1 with in_valid=1 and product 30, then products 1, 2, 3, 4.
  - Response: 30 is not accepted (in_ready=0). Result out_acc=10.
- Reset mid-DONE:
  - Stimulus: rst_n low while out_valid=1.
  - Response: out_valid=0, out_acc=0 and in_ready=1 immediately, asynchronously.
- Idle gaps:
  - Stimulus: in_valid toggled 1,0,0,1,1,0,1 with products 3,5,7,9.
  - Response: out_acc=24 after the 4th accepted beat only.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared types and defaults for the prod_accum block-sum accumulator.
package prod_accum_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam int IN_W_DEF  = 8;
  localparam int ACC_W_DEF = 16;
  localparam int LEN_DEF   = 4;

  // Beat counter width; a one-product block still needs a 1-bit counter.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/prod_accum_add.sv
// Combinational accumulator adder with carry-out.
// With PROD_ACCUM_SAT_EN defined a carry clamps the sum to all-ones; otherwise it wraps.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  prod,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + {{(ACC_W - IN_W + 1){1'b0}}, prod};
  assign carry = full[ACC_W];

`ifdef PROD_ACCUM_SAT_EN
  // A clamped accumulator plus any nonzero product carries again, so it stays clamped.
  assign sum = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Block accumulator: sums LEN unsigned products and hands the total off on valid/ready.
// Optional saturation is selected by PROD_ACCUM_SAT_EN inside prod_accum_add.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int                CNT_W    = cnt_width(LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             take;
  logic             last;

  // Handshake flags depend only on registered state and clr, never on in_valid/out_ready.
  assign in_ready  = (state == ST_ACC)  && !clr;
  assign out_valid = (state == ST_DONE) && !clr;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;
  assign last   = (cnt == CNT_LAST);

  assign out_acc = acc;
  assign out_ovf = ovf;

  prod_accum_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc   (acc),
    .prod  (in_prod),
    .sum   (sum),
    .carry (carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx is defaulted before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = ST_ACC;
    end else begin
      unique case (state)
        ST_ACC:  if (accept && last) state_nx = ST_DONE;
        ST_DONE: if (take)           state_nx = ST_ACC;
        default:                     state_nx = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      ovf <= ovf | carry;
      // The closing beat wraps the counter so it never passes LEN-1.
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end else if (take) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_LAST);

  a_one_side: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_DONE) && !out_ready && !clr
      |=> (state == ST_DONE) && $stable(acc) && $stable(ovf));

endmodule

// File: tb/tb_prod_accum.sv
// Randomized self-checking bench for prod_accum: default DUT plus an ACC_W=8, LEN=2 instance.
module tb_prod_accum;

`ifdef PROD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic [15:0] acc;
    logic        ovf;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0]  a_in_prod;
  logic [15:0] a_out_acc;

  logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0]  b_in_prod;
  logic [7:0]  b_out_acc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prod_accum u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (a_clr),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_prod   (a_in_prod),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_acc   (a_out_acc),
    .out_ovf   (a_out_ovf)
  );

  prod_accum #(.IN_W(8), .ACC_W(8), .LEN(2)) u_ovf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (b_clr),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_prod   (b_in_prod),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_acc   (b_out_acc),
    .out_ovf   (b_out_ovf)
  );

  // Reference: the true block total, reduced to the accumulator width by wrap or clamp.
  function automatic obs_t model(input bit sel, input logic ir, input logic ov, input int total);
    obs_t   r;
    int     w   = sel ? 8 : 16;
    longint lim = longint'(1) << w;
    r.ir = ir;
    r.ov = ov;
    if (longint'(total) >= lim) begin
      r.ovf = 1'b1;
      r.acc = SAT ? 16'(lim - 1) : 16'(longint'(total) % lim);
    end else begin
      r.ovf = 1'b0;
      r.acc = 16'(total);
    end
    return r;
  endfunction

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.ir = b_in_ready; o.ov = b_out_valid; o.acc = {8'h00, b_out_acc}; o.ovf = b_out_ovf;
    end else begin
      o.ir = a_in_ready; o.ov = a_out_valid; o.acc = a_out_acc; o.ovf = a_out_ovf;
    end
    return o;
  endfunction

  // Drive one cycle's inputs after the falling edge, sample, then let the rising edge pass.
  task automatic step(input bit sel, input logic v, input logic [7:0] p, input logic r,
                      input logic c, output obs_t o);
    @(negedge clk);
    if (sel) begin
      b_in_valid = v; b_in_prod = p; b_out_ready = r; b_clr = c;
    end else begin
      a_in_valid = v; a_in_prod = p; a_out_ready = r; a_clr = c;
    end
    #1;
    o = sample(sel);
    @(posedge clk);
  endtask

  task automatic send_block(input bit sel, input int prods[$], input int gap_max,
                            input int stall, input string tag);
    obs_t o, e;
    int   total = 0;
    foreach (prods[i]) begin
      int g = $urandom_range(gap_max, 0);
      repeat (g) begin
        step(sel, 1'b0, 8'($urandom), 1'($urandom), 1'b0, o);
        e = model(sel, 1'b1, 1'b0, total);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL %s gap: got %p want %p", tag, o, e); end
      end
      step(sel, 1'b1, 8'(prods[i]), 1'($urandom), 1'b0, o);
      e = model(sel, 1'b1, 1'b0, total);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s beat %0d: got %p want %p", tag, i, o, e); end
      total += prods[i];
    end
    for (int k = 0; k <= stall; k++) begin
      step(sel, 1'($urandom), 8'($urandom), (k == stall), 1'b0, o);
      e = model(sel, 1'b0, 1'b1, total);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s done %0d: got %p want %p", tag, k, o, e); end
    end
    step(sel, 1'b0, 8'h00, 1'b0, 1'b0, o);
    e = model(sel, 1'b1, 1'b0, 0);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL %s after: got %p want %p", tag, o, e); end
  endtask

  task automatic test_reset();
    obs_t o, e;
    a_clr = 0; a_in_valid = 0; a_in_prod = 0; a_out_ready = 0;
    b_clr = 0; b_in_valid = 0; b_in_prod = 0; b_out_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = sample(s[0]);
      e = model(s[0], 1'b1, 1'b0, 0);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset dut%0d: got %p want %p", s, o, e); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_block(1'b0, '{1, 15, 45, 50}, 0, 0, "basic");
  endtask

  task automatic test_backpressure();
    send_block(1'b0, '{1, 15, 45, 50}, 0, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 8; b++) begin
      send_block(1'b0, '{$urandom_range(255, 0), $urandom_range(255, 0),
                         $urandom_range(255, 0), $urandom_range(255, 0)},
                 $urandom_range(2, 0), $urandom_range(3, 0), "rand_a");
    end
    for (int b = 0; b < 8; b++) begin
      send_block(1'b1, '{$urandom_range(255, 0), $urandom_range(255, 0)},
                 $urandom_range(2, 0), $urandom_range(3, 0), "rand_b");
    end
  endtask

  task automatic test_overflow();
    send_block(1'b1, '{200, 100}, 0, 2, "overflow");
    send_block(1'b1, '{255, 0}, 1, 0, "ovf_edge");
    send_block(1'b1, '{128, 127}, 0, 0, "no_ovf_edge");
  endtask

  task automatic test_clear();
    obs_t o, e;
    step(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd20, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd30, 1'b0, 1'b1, o);
    e = model(1'b0, 1'b0, 1'b0, 30);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL clear_mid during: got %p want %p", o, e); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, o);
    e = model(1'b0, 1'b1, 1'b0, 0);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL clear_mid after: got %p want %p", o, e); end
    send_block(1'b0, '{1, 2, 3, 4}, 0, 0, "clear_resume");
    // Clear in DONE with a simultaneous output handshake: the result is discarded.
    foreach (e.acc[i]) ;
    step(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd6, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd7, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd8, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd9, 1'b1, 1'b1, o);
    n_checks++;
    if (o.ir !== 1'b0 || o.acc !== 16'd26) begin
      n_fail++; $display("FAIL clear_done during: got ir=%b acc=%0d want ir=0 acc=26", o.ir, o.acc);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, o);
    e = model(1'b0, 1'b1, 1'b0, 0);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL clear_done after: got %p want %p", o, e); end
  endtask

  task automatic test_reset_done();
    obs_t o, e;
    step(1'b0, 1'b1, 8'd40, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd41, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd42, 1'b0, 1'b0, o);
    step(1'b0, 1'b1, 8'd43, 1'b0, 1'b0, o);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    o = sample(1'b0);
    e = model(1'b0, 1'b0, 1'b1, 166);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_done before: got %p want %p", o, e); end
    #1 rst_n = 1'b0;
    #1;
    o = sample(1'b0);
    e = model(1'b0, 1'b1, 1'b0, 0);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_done async: got %p want %p", o, e); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_done after: got %p want %p", o, e); end
  endtask

  task automatic test_idle_gaps();
    obs_t o, e;
    bit   v[7]     = '{1, 0, 0, 1, 1, 0, 1};
    int   prods[4] = '{3, 5, 7, 9};
    int   idx = 0;
    int   total = 0;
    for (int k = 0; k < 7; k++) begin
      step(1'b0, v[k], v[k] ? 8'(prods[idx]) : 8'($urandom), 1'b1, 1'b0, o);
      e = model(1'b0, 1'b1, 1'b0, total);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL idle cycle %0d: got %p want %p", k, o, e); end
      if (v[k]) begin
        total += prods[idx];
        idx++;
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, o);
    e = model(1'b0, 1'b0, 1'b1, 24);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL idle done: got %p want %p", o, e); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, o);
    e = model(1'b0, 1'b1, 1'b0, 0);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL idle after: got %p want %p", o, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_clear();
    test_idle_gaps();
    test_back_to_back();
    test_reset_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
